// File: rtl/os_processing_element.sv
// rtl/os_processing_element.sv - output-stationary systolic PE with a pipelined multiplier and a local MAC
// Forwards act/wei east/south; products pass through STAGE+INTERMEDIATE_PIPELINE_STAGE registers before accumulation.
module os_processing_element #(
    parameter int WIDTH_A                     = 16,
    parameter int WIDTH_B                     = 16,
    parameter int WIDTH_MAC                   = 48,
    parameter int WIDTH_T                     = 2,
    parameter int ZERO_GATING_MULT            = 1,
    parameter int ZERO_GATING_ADD             = 1,
    parameter int MM_APPROX                   = 1,
    parameter int M_APPROX                    = 1,
    parameter int AA_APPROX                   = 1,
    parameter int A_APPROX                    = 1,
    parameter int MUL_TYPE                    = 0,
    parameter int ADD_TYPE                    = 0,
    parameter int STAGE                       = 5,
    parameter int ARITHMETIC                  = 0,
    parameter int SIGNED                      = 0,
    parameter int INTERMEDIATE_PIPELINE_STAGE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH_A-1:0]   act,
    input  logic [WIDTH_B-1:0]   wei,
    input  logic [WIDTH_MAC-1:0] MAC_IN,
    input  logic                 pipeline_en,
    input  logic                 reg_clear,
    input  logic                 cell_en,
    input  logic                 cell_sc_en,
    input  logic                 c_switch,
    input  logic                 cscan_en,
    input  logic [WIDTH_T-1:0]   Thres,
    output logic                 cell_out,
    output logic                 c_switch_out,
    output logic [WIDTH_A-1:0]   act_out,
    output logic [WIDTH_B-1:0]   wei_out,
    output logic [WIDTH_MAC-1:0] MAC_out
);

    localparam int DEPTH = STAGE + INTERMEDIATE_PIPELINE_STAGE;
    localparam bit APX_MUL = (MM_APPROX != 0) && (M_APPROX != 0);
    localparam bit APX_ADD = (AA_APPROX != 0) && (A_APPROX != 0);

    logic                 w_en;
    logic [WIDTH_A-1:0]   w_a_opnd;
    logic [WIDTH_B-1:0]   w_b_opnd;
    logic [WIDTH_MAC-1:0] w_a_ext;
    logic [WIDTH_MAC-1:0] w_b_ext;
    logic [WIDTH_MAC-1:0] w_mul_raw;
    logic [WIDTH_MAC-1:0] w_prod;
    logic                 w_opnd_zero;
    logic [WIDTH_MAC-1:0] w_tail;
    logic [WIDTH_MAC-1:0] w_addend;
    logic [WIDTH_MAC-1:0] w_sum;
    logic                 w_add_skip;

    logic                 r_act_vld;
    logic                 r_started;
    logic [WIDTH_MAC-1:0] r_stage [DEPTH];
    logic [DEPTH-1:0]     r_vld;

    assign w_en = pipeline_en & cell_en;

    // Truncation of the low Thres bits trades accuracy for switching activity.
    assign w_a_opnd = APX_MUL ? (act_out & ({WIDTH_A{1'b1}} << Thres)) : act_out;
    assign w_b_opnd = APX_MUL ? (wei_out & ({WIDTH_B{1'b1}} << Thres)) : wei_out;
    assign w_opnd_zero = (w_a_opnd == '0) || (w_b_opnd == '0);

    generate
        if (SIGNED != 0) begin : g_sext
            assign w_a_ext = {{(WIDTH_MAC-WIDTH_A){w_a_opnd[WIDTH_A-1]}}, w_a_opnd};
            assign w_b_ext = {{(WIDTH_MAC-WIDTH_B){w_b_opnd[WIDTH_B-1]}}, w_b_opnd};
        end else begin : g_zext
            assign w_a_ext = {{(WIDTH_MAC-WIDTH_A){1'b0}}, w_a_opnd};
            assign w_b_ext = {{(WIDTH_MAC-WIDTH_B){1'b0}}, w_b_opnd};
        end

        // Only integer arithmetic exists; other architecture codes fall back to the exact multiply.
        if ((MUL_TYPE == 0) && (ARITHMETIC == 0)) begin : g_mul_exact
            assign w_mul_raw = w_a_ext * w_b_ext;
        end else begin : g_mul_fallback
            assign w_mul_raw = w_a_ext * w_b_ext;
        end
    endgenerate

    assign w_prod = ((ZERO_GATING_MULT != 0) && w_opnd_zero) ? '0 : w_mul_raw;

    assign w_tail     = r_stage[DEPTH-1];
    assign w_addend   = APX_ADD ? (w_tail & ({WIDTH_MAC{1'b1}} << Thres)) : w_tail;
    assign w_add_skip = (ZERO_GATING_ADD != 0) && (w_addend == '0);

    generate
        if (ADD_TYPE == 0) begin : g_add_exact
            assign w_sum = MAC_out + w_addend;
        end else begin : g_add_fallback
            assign w_sum = MAC_out + w_addend;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_out     <= 1'b0;
            c_switch_out <= 1'b0;
        end else if (reg_clear) begin
            cell_out     <= 1'b0;
            c_switch_out <= 1'b0;
        end else begin
            cell_out     <= cell_sc_en;
            c_switch_out <= c_switch;
        end
    end

    // The first sample after reset/clear is tagged invalid so it never reaches the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_out   <= '0;
            wei_out   <= '0;
            r_act_vld <= 1'b0;
            r_started <= 1'b0;
        end else if (reg_clear) begin
            act_out   <= '0;
            wei_out   <= '0;
            r_act_vld <= 1'b0;
            r_started <= 1'b0;
        end else if (w_en) begin
            act_out   <= act;
            wei_out   <= wei;
            r_act_vld <= r_started;
            r_started <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
                r_vld[i]   <= 1'b0;
            end
        end else if (reg_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
                r_vld[i]   <= 1'b0;
            end
        end else if (w_en) begin
            r_stage[0] <= w_prod;
            r_vld[0]   <= r_act_vld;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
                r_vld[i]   <= r_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MAC_out <= '0;
        end else if (reg_clear) begin
            MAC_out <= '0;
        end else if (w_en) begin
            if (cscan_en) begin
                MAC_out <= MAC_IN;
            end else if (r_vld[DEPTH-1] && !w_add_skip) begin
                MAC_out <= w_sum;
            end
        end
    end

endmodule

// File: tb/tb_os_processing_element.sv
// tb/tb_os_processing_element.sv - directed plan plus randomized run against a queue-based latency model
// The model treats the multiplier path as a fixed-length FIFO advanced only on enabled edges.
module tb_os_processing_element;

    localparam int WA    = 16;
    localparam int WB    = 16;
    localparam int WM    = 48;
    localparam int WT    = 2;
    localparam int STG   = 5;
    localparam int IPS   = 0;
    localparam int LAT   = STG + IPS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WA-1:0] act;
    logic [WB-1:0] wei;
    logic [WM-1:0] mac_in;
    logic          pipeline_en, reg_clear, cell_en, cell_sc_en, c_switch, cscan_en;
    logic [WT-1:0] thres;
    logic          cell_out, c_switch_out;
    logic [WA-1:0] act_out;
    logic [WB-1:0] wei_out;
    logic [WM-1:0] mac_out;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [WM-1:0] p;
        logic          v;
    } item_t;

    item_t         m_q[$];
    logic [WM-1:0] m_mac;
    logic [WA-1:0] m_act;
    logic [WB-1:0] m_wei;
    logic          m_avld, m_started, m_cell, m_csw;

    os_processing_element #(
        .WIDTH_A(WA), .WIDTH_B(WB), .WIDTH_MAC(WM), .WIDTH_T(WT),
        .STAGE(STG), .INTERMEDIATE_PIPELINE_STAGE(IPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .act(act), .wei(wei), .MAC_IN(mac_in),
        .pipeline_en(pipeline_en), .reg_clear(reg_clear), .cell_en(cell_en),
        .cell_sc_en(cell_sc_en), .c_switch(c_switch), .cscan_en(cscan_en),
        .Thres(thres), .cell_out(cell_out), .c_switch_out(c_switch_out),
        .act_out(act_out), .wei_out(wei_out), .MAC_out(mac_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < LAT; i++) m_q.push_back('0);
        m_mac = '0; m_act = '0; m_wei = '0;
        m_avld = 1'b0; m_started = 1'b0; m_cell = 1'b0; m_csw = 1'b0;
    endtask

    function automatic logic [WM-1:0] trunc_prod(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                                 input logic [WT-1:0] t);
        longint unsigned am, bm;
        am = longint'(a) & ~((64'd1 << t) - 64'd1);
        bm = longint'(b) & ~((64'd1 << t) - 64'd1);
        return WM'(am * bm);
    endfunction

    task automatic model_step();
        item_t it;
        logic [WM-1:0] addend;
        if (!rst_n || reg_clear) begin
            model_reset();
        end else begin
            m_cell = cell_sc_en;
            m_csw  = c_switch;
            if (pipeline_en && cell_en) begin
                it = m_q.pop_front();
                addend = it.p & ~((WM'(1) << thres) - WM'(1));
                if (cscan_en) m_mac = mac_in;
                else if (it.v) m_mac = m_mac + addend;
                m_q.push_back('{p: trunc_prod(m_act, m_wei, thres), v: m_avld});
                m_act = act; m_wei = wei;
                m_avld = m_started; m_started = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("mdl_mac", 64'(mac_out), 64'(m_mac));
        check("mdl_act", 64'(act_out), 64'(m_act));
        check("mdl_wei", 64'(wei_out), 64'(m_wei));
        check("mdl_cell", 64'(cell_out), 64'(m_cell));
        check("mdl_csw", 64'(c_switch_out), 64'(m_csw));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_aw(input int v);
        act = WA'(v); wei = WB'(v);
    endtask

    initial begin
        rst_n = 1'b0; set_aw(1); mac_in = '0; pipeline_en = 1'b1; cell_en = 1'b1;
        reg_clear = 1'b0; cell_sc_en = 1'b1; c_switch = 1'b0; cscan_en = 1'b0; thres = '0;
        model_reset();

        for (int i = 0; i < 16; i++) begin
            if (i == 8) set_aw(2);
            tick();
            check("rst_mac", 64'(mac_out), 64'd0);
            check("rst_act", 64'(act_out), 64'd0);
            check("rst_cell", 64'(cell_out), 64'd0);
        end

        rst_n = 1'b1; set_aw(1);
        ticks(8);
        check("p1_mac", 64'(mac_out), 64'd1);
        check("p1_act", 64'(act_out), 64'd1);
        check("p1_wei", 64'(wei_out), 64'd1);
        check("p1_cell", 64'(cell_out), 64'd1);
        check("p1_csw", 64'(c_switch_out), 64'd0);
        reg_clear = 1'b1; ticks(8);
        check("clr_mac", 64'(mac_out), 64'd0);
        check("clr_act", 64'(act_out), 64'd0);
        check("clr_cell", 64'(cell_out), 64'd0);
        reg_clear = 1'b0; set_aw(2); ticks(8);
        check("p1_mac4", 64'(mac_out), 64'd4);

        reg_clear = 1'b1; tick(); reg_clear = 1'b0;
        set_aw(1); ticks(8); check("p2_m1", 64'(mac_out), 64'd1);
        set_aw(2); ticks(8); check("p2_m15", 64'(mac_out), 64'd15);
        set_aw(3); ticks(8); check("p2_m57", 64'(mac_out), 64'd57);
        cell_en = 1'b0;
        for (int v = 4; v <= 6; v++) begin set_aw(v); ticks(8); end
        check("p2_hold", 64'(mac_out), 64'd57);
        check("p2_act", 64'(act_out), 64'd3);
        check("p2_wei", 64'(wei_out), 64'd3);
        check("p2_cell", 64'(cell_out), 64'd1);
        cell_en = 1'b1;

        reg_clear = 1'b1; tick(); reg_clear = 1'b0;
        set_aw(1); ticks(8); check("p3_m1", 64'(mac_out), 64'd1);
        pipeline_en = 1'b0; set_aw(2); ticks(8);
        check("p3_hold", 64'(mac_out), 64'd1);
        check("p3_act", 64'(act_out), 64'd1);
        pipeline_en = 1'b1; set_aw(3);
        tick();     check("p3_m2", 64'(mac_out), 64'd2);
        ticks(5);   check("p3_m7", 64'(mac_out), 64'd7);
        tick();     check("p3_m16", 64'(mac_out), 64'd16);
        pipeline_en = 1'b0; ticks(8); check("p3_h16", 64'(mac_out), 64'd16);
        set_aw(5); pipeline_en = 1'b1;
        tick();     check("p3_m25", 64'(mac_out), 64'd25);
        ticks(5);   check("p3_m70", 64'(mac_out), 64'd70);
        tick();     check("p3_m95", 64'(mac_out), 64'd95);
        pipeline_en = 1'b0; set_aw(6); ticks(8); check("p3_h95", 64'(mac_out), 64'd95);
        pipeline_en = 1'b1;
        tick();     check("p3_m120", 64'(mac_out), 64'd120);
        ticks(5);   check("p3_m245", 64'(mac_out), 64'd245);

        cscan_en = 1'b1; mac_in = 48'h123; tick();
        check("scan", 64'(mac_out), 64'h123);
        cscan_en = 1'b0;

        reg_clear = 1'b1; tick(); reg_clear = 1'b0;
        thres = 2'd1; set_aw(3); ticks(8);
        check("apx_m4", 64'(mac_out), 64'd4);
        tick(); check("apx_m8", 64'(mac_out), 64'd8);

        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 199) != 0);
            reg_clear   = ($urandom_range(0, 49) == 0);
            pipeline_en = ($urandom_range(0, 9) < 8);
            cell_en     = ($urandom_range(0, 9) < 9);
            cscan_en    = ($urandom_range(0, 29) == 0);
            cell_sc_en  = 1'($urandom);
            c_switch    = 1'($urandom);
            thres       = WT'($urandom);
            act         = ($urandom_range(0, 4) == 0) ? '0 : WA'($urandom);
            wei         = ($urandom_range(0, 4) == 0) ? '0 : WB'($urandom);
            mac_in      = ($urandom_range(0, 1) == 0) ? {16'hFFFF, 32'($urandom)}
                                                       : {16'($urandom), 32'($urandom)};
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
